// File: rtl/rect_loop_ctrl.sv
// Owner of the ROWS x COLS bit matrix: loads, four-corner flips, and a
// one-candidate-per-cycle scan for rectangle loops with optional in-place fixing.
module rect_loop_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int N  = ROWS * COLS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [N-1:0]  load_data,
    input  logic          cmd_valid,
    input  logic [RW-1:0] cmd_r1,
    input  logic [RW-1:0] cmd_r2,
    input  logic [CW-1:0] cmd_c1,
    input  logic [CW-1:0] cmd_c2,
    input  logic          scan_start,
    input  logic          scan_fix,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [RW-1:0] hit_r1,
    output logic [RW-1:0] hit_r2,
    output logic [CW-1:0] hit_c1,
    output logic [CW-1:0] hit_c2,
    output logic [7:0]    fix_count,
    output logic          cmd_err,
    output logic [N-1:0]  m_out
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  m_q, m_d;
    logic          found_q, found_d;
    logic [RW-1:0] hr1_q, hr1_d, hr2_q, hr2_d;
    logic [CW-1:0] hc1_q, hc1_d, hc2_q, hc2_d;
    logic [7:0]    fc_q, fc_d;
    logic          fix_q, fix_d;
    logic [RW-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [CW-1:0] c1_q, c1_d, c2_q, c2_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;

    logic [N-1:0]  cand_mask;
    logic          cand_hit;
    logic          cmd_bad;

    // Cell (0,0) is the MSB.
    function automatic logic [N-1:0] onehot(input int r, input int c);
        return N'(1) << (N - 1 - (r * COLS + c));
    endfunction

    // Coincident corners collapse in the OR, so they flip only once.
    function automatic logic [N-1:0] flip_mask(input int a, input int b, input int c,
                                               input int d);
        return onehot(a, c) | onehot(a, d) | onehot(b, c) | onehot(b, d);
    endfunction

    assign cand_mask = flip_mask(int'(r1_q), int'(r2_q), int'(c1_q), int'(c2_q));
    assign cand_hit  = (m_q & cand_mask) == cand_mask;
    assign cmd_bad   = (int'(cmd_r1) >= ROWS) || (int'(cmd_r2) >= ROWS) ||
                       (int'(cmd_c1) >= COLS) || (int'(cmd_c2) >= COLS);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        found_d = found_q;
        hr1_d   = hr1_q;
        hr2_d   = hr2_q;
        hc1_d   = hc1_q;
        hc2_d   = hc2_q;
        fc_d    = fc_q;
        fix_d   = fix_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    m_d     = load_data;
                    found_d = 1'b0;
                    hr1_d   = '0;
                    hr2_d   = '0;
                    hc1_d   = '0;
                    hc2_d   = '0;
                end else if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        m_d = m_q ^ flip_mask(int'(cmd_r1), int'(cmd_r2),
                                              int'(cmd_c1), int'(cmd_c2));
                    end
                end else if (scan_start) begin
                    found_d = 1'b0;
                    hr1_d   = '0;
                    hr2_d   = '0;
                    hc1_d   = '0;
                    hc2_d   = '0;
                    fc_d    = '0;
                    fix_d   = scan_fix;
                    r1_d    = '0;
                    r2_d    = RW'(1);
                    c1_d    = '0;
                    c2_d    = CW'(1);
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cand_hit) begin
                    found_d = 1'b1;
                    hr1_d   = r1_q;
                    hr2_d   = r2_q;
                    hc1_d   = c1_q;
                    hc2_d   = c2_q;
                    if (fix_q) begin
                        m_d = m_q ^ cand_mask;
                        if (fc_q != 8'hFF) fc_d = fc_q + 8'd1;
                    end else begin
                        state_d = StDone;
                    end
                end
                if (state_d == StScan) begin
                    // Advance the nested r1/r2/c1/c2 loop; innermost index first.
                    if (int'(c2_q) < COLS - 1) begin
                        c2_d = c2_q + 1'b1;
                    end else if (int'(c1_q) < COLS - 2) begin
                        c1_d = c1_q + 1'b1;
                        c2_d = CW'(int'(c1_q) + 2);
                    end else if (int'(r2_q) < ROWS - 1) begin
                        r2_d = r2_q + 1'b1;
                        c1_d = '0;
                        c2_d = CW'(1);
                    end else if (int'(r1_q) < ROWS - 2) begin
                        r1_d = r1_q + 1'b1;
                        r2_d = RW'(int'(r1_q) + 2);
                        c1_d = '0;
                        c2_d = CW'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        done_d = (state_d == StDone);
        busy_d = (state_d == StScan);
        rdy_d  = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            found_q <= 1'b0;
            hr1_q   <= '0;
            hr2_q   <= '0;
            hc1_q   <= '0;
            hc2_q   <= '0;
            fc_q    <= '0;
            fix_q   <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            found_q <= found_d;
            hr1_q   <= hr1_d;
            hr2_q   <= hr2_d;
            hc1_q   <= hc1_d;
            hc2_q   <= hc2_d;
            fc_q    <= fc_d;
            fix_q   <= fix_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = rdy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign hit_r1    = hr1_q;
    assign hit_r2    = hr2_q;
    assign hit_c1    = hc1_q;
    assign hit_c2    = hc2_q;
    assign fix_count = fc_q;
    assign cmd_err   = err_q;
    assign m_out     = m_q;

endmodule

// File: tb/tb_rect_loop_ctrl.sv
// Scoreboard bench for rect_loop_ctrl: 4x4 main instance plus a 3x3 instance for
// out-of-range command rejection.
module tb_rect_loop_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, cmd_valid, scan_start, scan_fix;
    logic [15:0] load_data;
    logic [1:0]  cmd_r1, cmd_r2, cmd_c1, cmd_c2;
    logic        in_ready, busy, done, found, cmd_err;
    logic [1:0]  hit_r1, hit_r2, hit_c1, hit_c2;
    logic [7:0]  fix_count;
    logic [15:0] m_out;

    logic        load_valid3, cmd_valid3, zero3;
    logic [8:0]  ld3, m3;
    logic        rdy3, busy3, done3, found3, err3;
    logic [1:0]  h3r1, h3r2, h3c1, h3c2;
    logic [7:0]  fc3;

    always #5 clk = ~clk;

    rect_loop_ctrl dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .cmd_valid(cmd_valid), .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1),
        .cmd_c2(cmd_c2), .scan_start(scan_start), .scan_fix(scan_fix),
        .in_ready(in_ready), .busy(busy), .done(done), .found(found),
        .hit_r1(hit_r1), .hit_r2(hit_r2), .hit_c1(hit_c1), .hit_c2(hit_c2),
        .fix_count(fix_count), .cmd_err(cmd_err), .m_out(m_out)
    );

    rect_loop_ctrl #(.ROWS(3), .COLS(3)) dut3 (
        .clk(clk), .rst(rst), .load_valid(load_valid3), .load_data(ld3),
        .cmd_valid(cmd_valid3), .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1),
        .cmd_c2(cmd_c2), .scan_start(zero3), .scan_fix(zero3),
        .in_ready(rdy3), .busy(busy3), .done(done3), .found(found3),
        .hit_r1(h3r1), .hit_r2(h3r2), .hit_c1(h3c1), .hit_c2(h3c2),
        .fix_count(fc3), .cmd_err(err3), .m_out(m3)
    );

    typedef struct {
        logic [15:0] m;
        logic        found;
        logic [7:0]  hits;
        logic [7:0]  fc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mexp[$];
    logic [15:0] model_m;
    int          asserts = 0;
    int          fails   = 0;

    function automatic logic [15:0] model_flip(input logic [15:0] m, input int r1, input int r2,
                                               input int c1, input int c2);
        logic [15:0] t;
        t = m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if ((r == r1 || r == r2) && (c == c1 || c == c2))
                    t[15-(r*4+c)] = ~t[15-(r*4+c)];
        return t;
    endfunction

    function automatic exp_t model_scan(input logic [15:0] m, input bit fix);
        exp_t e;
        int   k;
        bit   stop;
        e.m = m; e.found = 1'b0; e.hits = 8'h00; e.fc = 8'h00; e.lat = 37;
        k = 0; stop = 1'b0;
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 4; b++)
                for (int c = 0; c < 3; c++)
                    for (int d = c + 1; d < 4; d++) begin
                        if (!stop && e.m[15-(a*4+c)] && e.m[15-(a*4+d)] &&
                            e.m[15-(b*4+c)] && e.m[15-(b*4+d)]) begin
                            e.found = 1'b1;
                            e.hits  = {2'(a), 2'(b), 2'(c), 2'(d)};
                            if (fix) begin
                                e.m[15-(a*4+c)] = 1'b0; e.m[15-(a*4+d)] = 1'b0;
                                e.m[15-(b*4+c)] = 1'b0; e.m[15-(b*4+d)] = 1'b0;
                                e.fc = e.fc + 8'd1;
                            end else begin
                                stop  = 1'b1;
                                e.lat = 2 + k;
                            end
                        end
                        k++;
                    end
        return e;
    endfunction

    task automatic do_load(input logic [15:0] d);
        logic [15:0] want;
        mexp.push_back(d);
        load_valid = 1'b1; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
        want = mexp.pop_front();
        model_m = d;
        asserts++;
        if (m_out !== want) begin
            fails++; $display("FAIL load m_out: got %h want %h", m_out, want);
        end
        asserts++;
        if (found !== 1'b0) begin
            fails++; $display("FAIL load clears found: got %b want 0", found);
        end
    endtask

    task automatic do_cmd(input int r1, input int r2, input int c1, input int c2);
        logic [15:0] want;
        model_m = model_flip(model_m, r1, r2, c1, c2);
        mexp.push_back(model_m);
        cmd_valid = 1'b1;
        cmd_r1 = 2'(r1); cmd_r2 = 2'(r2); cmd_c1 = 2'(c1); cmd_c2 = 2'(c2);
        @(negedge clk);
        cmd_valid = 1'b0;
        want = mexp.pop_front();
        asserts++;
        if (m_out !== want) begin
            fails++; $display("FAIL cmd m_out: got %h want %h", m_out, want);
        end
        asserts++;
        if ({cmd_err, in_ready} !== 2'b01) begin
            fails++; $display("FAIL cmd err/ready: got %b want 01", {cmd_err, in_ready});
        end
    endtask

    task automatic run_scan(input bit fix, input bit disturb);
        exp_t e;
        int   lat;
        int   busy_n;
        sb.push_back(model_scan(model_m, fix));
        scan_start = 1'b1; scan_fix = fix;
        @(negedge clk);
        scan_start = 1'b0;
        lat = 1; busy_n = 0;
        while (!done && lat < 60) begin
            if (busy) busy_n++;
            // Requests while scanning must be ignored.
            if (disturb && lat == 5) begin
                load_valid = 1'b1; load_data = 16'hFFFF;
                cmd_valid = 1'b1; cmd_r1 = 2'd0; cmd_r2 = 2'd1; cmd_c1 = 2'd0; cmd_c2 = 2'd1;
            end else begin
                load_valid = 1'b0; cmd_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        load_valid = 1'b0; cmd_valid = 1'b0;
        e = sb.pop_front();
        asserts++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL scan timeout: done got %b want 1", done);
        end
        asserts++;
        if (lat != e.lat) begin
            fails++; $display("FAIL scan latency: got %0d want %0d", lat, e.lat);
        end
        asserts++;
        if (busy_n != e.lat - 1) begin
            fails++; $display("FAIL scan busy cycles: got %0d want %0d", busy_n, e.lat - 1);
        end
        asserts++;
        if (m_out !== e.m) begin
            fails++; $display("FAIL scan m_out: got %h want %h", m_out, e.m);
        end
        asserts++;
        if (found !== e.found) begin
            fails++; $display("FAIL scan found: got %b want %b", found, e.found);
        end
        asserts++;
        if ({hit_r1, hit_r2, hit_c1, hit_c2} !== e.hits) begin
            fails++;
            $display("FAIL scan hit: got %h want %h", {hit_r1, hit_r2, hit_c1, hit_c2}, e.hits);
        end
        asserts++;
        if (fix_count !== e.fc) begin
            fails++; $display("FAIL scan fix_count: got %0d want %0d", fix_count, e.fc);
        end
        asserts++;
        if ({in_ready, busy} !== 2'b00) begin
            fails++; $display("FAIL scan done-state flags: got %b want 00", {in_ready, busy});
        end
        @(negedge clk);
        asserts++;
        if ({done, in_ready, found} !== {2'b01, e.found}) begin
            fails++;
            $display("FAIL scan after done: got %b want %b", {done, in_ready, found},
                     {2'b01, e.found});
        end
        model_m = e.m;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_valid = 0; cmd_valid = 0; scan_start = 0; scan_fix = 0; load_data = '0;
        cmd_r1 = 0; cmd_r2 = 0; cmd_c1 = 0; cmd_c2 = 0;
        load_valid3 = 0; cmd_valid3 = 0; zero3 = 0; ld3 = '0;
        repeat (2) @(negedge clk);
        asserts++;
        if ({m_out, found, fix_count, done, busy, cmd_err, in_ready, rdy3} !== '0) begin
            fails++;
            $display("FAIL reset state: got m=%h found=%b fc=%0d d=%b b=%b e=%b rdy=%b/%b want 0",
                     m_out, found, fix_count, done, busy, cmd_err, in_ready, rdy3);
        end
        rst = 1'b0;
        @(negedge clk);
        asserts++;
        if ({in_ready, busy, done} !== 3'b100) begin
            fails++; $display("FAIL reset release: got %b want 100", {in_ready, busy, done});
        end
        model_m = 16'h0000;
    endtask

    task automatic test_flips;
        do_cmd(0, 2, 1, 3);
        asserts++;
        if (m_out !== 16'h5050) begin fails++; $display("FAIL flip4: got %h want 5050", m_out); end
        do_cmd(1, 1, 2, 2);
        asserts++;
        if (m_out !== 16'h5250) begin fails++; $display("FAIL flip1: got %h want 5250", m_out); end
        do_cmd(1, 1, 0, 3);
        asserts++;
        if (m_out !== 16'h5B50) begin fails++; $display("FAIL flip2: got %h want 5B50", m_out); end
    endtask

    task automatic test_detect;
        do_load(16'hCC00);
        run_scan(1'b0, 1'b0);
        do_load(16'h8421);
        run_scan(1'b0, 1'b1);
    endtask

    task automatic test_fix_all;
        do_load(16'hFFFF);
        run_scan(1'b1, 1'b0);
        asserts++;
        if ({m_out, fix_count} !== {16'h0000, 8'd4}) begin
            fails++; $display("FAIL fix all-ones: got m=%h fc=%0d want 0000/4", m_out, fix_count);
        end
    endtask

    task automatic test_priority;
        load_valid = 1'b1; load_data = 16'h1234;
        cmd_valid = 1'b1; cmd_r1 = 2'd0; cmd_r2 = 2'd1; cmd_c1 = 2'd0; cmd_c2 = 2'd1;
        scan_start = 1'b1; scan_fix = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; cmd_valid = 1'b0; scan_start = 1'b0;
        asserts++;
        if ({m_out, found, busy, in_ready} !== {16'h1234, 3'b001}) begin
            fails++;
            $display("FAIL priority: got m=%h f=%b b=%b r=%b want 1234/0/0/1",
                     m_out, found, busy, in_ready);
        end
        @(negedge clk);
        asserts++;
        if ({busy, done, fix_count} !== {2'b00, 8'd4}) begin
            fails++; $display("FAIL priority no scan: got %b/%0d want 00/4", {busy, done}, fix_count);
        end
        model_m = 16'h1234;
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            do_load(16'($urandom));
            run_scan(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_reset_mid_scan;
        int seen;
        do_load(16'hFFFF);
        scan_start = 1'b1; scan_fix = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        asserts++;
        if ({m_out, found, hit_r1, hit_r2, hit_c1, hit_c2, fix_count, done, busy, cmd_err,
             in_ready} !== '0) begin
            fails++;
            $display("FAIL mid-scan reset: got m=%h f=%b fc=%0d b=%b r=%b want 0",
                     m_out, found, fix_count, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        asserts++;
        if (seen != 0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL post-abort: got done count %0d ready %b want 0/1", seen, in_ready);
        end
        model_m = 16'h0000;
    endtask

    task automatic test_cmd_err;
        load_valid3 = 1'b1; ld3 = 9'h1FF;
        @(negedge clk);
        load_valid3 = 1'b0;
        cmd_valid3 = 1'b1; cmd_r1 = 2'd0; cmd_r2 = 2'd3; cmd_c1 = 2'd0; cmd_c2 = 2'd1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        asserts++;
        if ({err3, m3} !== {1'b1, 9'h1FF}) begin
            fails++; $display("FAIL cmd_err pulse: got err=%b m=%h want 1/1ff", err3, m3);
        end
        @(negedge clk);
        asserts++;
        if (err3 !== 1'b0) begin fails++; $display("FAIL cmd_err width: got %b want 0", err3); end
        cmd_valid3 = 1'b1; cmd_r1 = 2'd0; cmd_r2 = 2'd2; cmd_c1 = 2'd0; cmd_c2 = 2'd2;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        asserts++;
        if ({err3, m3} !== {1'b0, 9'h0BA}) begin
            fails++; $display("FAIL 3x3 flip: got err=%b m=%h want 0/0ba", err3, m3);
        end
    endtask

    initial begin
        test_reset();
        test_flips();
        test_detect();
        test_fix_all();
        test_priority();
        test_random();
        test_reset_mid_scan();
        test_cmd_err();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/rect_loop_ctrl.md
Name: rect_loop_ctrl

Overview:
Sequencer that owns the ROWS x COLS bit-matrix register and applies four-corner rectangle flips to it. It accepts matrix loads and single flip commands, and runs a scan over all axis-aligned rectangles to find one whose four corners are all 1 (a "rectangle loop"). In fix mode the scan flips every loop it finds until none remain. It sits between the host/testbench control and the flip datapath, and is the only writer of the matrix.

Parameters:
ROWS, 4, matrix rows (>=2)
COLS, 4, matrix columns (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
load_valid  in  1  load request
load_data  in  ROWS*COLS  new matrix
cmd_valid  in  1  flip command request
cmd_r1, cmd_r2  in  RW=$clog2(ROWS)  flip rows
cmd_c1, cmd_c2  in  CW=$clog2(COLS)  flip columns
scan_start  in  1  scan request
scan_fix  in  1  sampled with scan_start; 1 = fix mode
in_ready  out  1  high when all requests can be accepted (state IDLE)
busy  out  1  high in SCAN
done  out  1  one-cycle pulse when a scan ends
found  out  1  scan result, held
hit_r1, hit_r2  out  RW  rows of the reported rectangle
hit_c1, hit_c2  out  CW  columns of the reported rectangle
fix_count  out  8  loops flipped in the last scan, saturating at 255
cmd_err  out  1  one-cycle pulse when a command is rejected
m_out  out  ROWS*COLS  current matrix

Behaviour:
- Bit map: cell (r,c) is bit (ROWS*COLS-1)-(r*COLS+c). Cell (0,0) is the MSB.
- Flip mask: OR of the one-hot masks of (r1,c1), (r1,c2), (r2,c1), (r2,c2). The new matrix is the old matrix XOR the mask. Coincident corners therefore flip once: r1==r2 with c1!=c2 flips 2 bits; r1==r2 with c1==c2 flips 1 bit.
- States: IDLE, SCAN, DONE. All outputs registered.
- Reset: state IDLE. m_out, found, hit_*, fix_count, done, busy, cmd_err all 0. in_ready 0 while rst is high, 1 in the first cycle after release. Reset mid-scan aborts immediately with no done pulse.
- IDLE: in_ready=1. When several requests are valid in the same cycle, priority is load > cmd > scan. The lower-priority requests in that cycle are ignored, not queued.
  - Load: m_out=load_data next cycle. found and hit_* are cleared.
  - Cmd: m_out updates next cycle. Any index >= ROWS or >= COLS means no change and cmd_err pulses next cycle. This can only happen for non-power-of-2 sizes.
  - Scan: clears found, hit_*, fix_count, and latches scan_fix. Goes to SCAN with candidate 0.
- SCAN: evaluates one candidate per cycle against the current matrix.
  - Order is nested loops, outermost first: r1 in 0..ROWS-2, r2 in r1+1..ROWS-1, c1 in 0..COLS-2, c2 in c1+1..COLS-1.
  - There are N = C(ROWS,2)*C(COLS,2) candidates; N=36 for 4x4.
  - Hit: all four corner bits are 1.
  - Detect mode: on the first hit, found=1, hit_*=candidate, go to DONE.
  - Fix mode: on every hit, apply the flip (clearing all four corners) in that cycle, set found=1, load hit_*=candidate, fix_count+=1 (saturating), and continue with the next candidate. Flips only clear bits, so a single pass leaves the matrix loop-free.
  - After the last candidate, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. found, hit_*, and fix_count hold until the next load or scan start.
- Timing: a scan accepted at cycle T evaluates candidate i in cycle T+1+i. If candidate k ends the scan, DONE (done=1) is in cycle T+2+k. A full pass on 4x4 gives done at T+37.
- in_ready=0 in SCAN and DONE. Requests in those states are ignored and have no effect.

Test Plan:
- Single and degenerate flips: rst, m=0, cmd(r1=0,r2=2,c1=1,c2=3) -> m_out=16'h5050 next cycle. cmd(1,1,2,2) -> 16'h5250. cmd(1,1,0,3) -> 16'h5B50. in_ready stays 1.
- Detect hit: load 16'hCC00, scan_start, fix=0 at T -> done at T+2, found=1, hit=(0,1,0,1), m_out unchanged.
- Detect miss: load 16'h8421, scan at T -> busy T+1..T+36, done at T+37, found=0, hit_*=0.
- Fix all-ones: load 16'hFFFF, scan fix=1 -> done at T+37, m_out=16'h0000, found=1, fix_count=4, hit=(2,3,2,3).
- Priority and ignore: load_valid, cmd_valid and scan_start high together -> only the load takes effect. cmd_valid during SCAN -> no matrix change.
- Reset mid-scan and cmd_err: rst asserted at T+10 of a scan -> all outputs 0 asynchronously, no done. For ROWS=3: cmd with r2=3 -> cmd_err pulse, m_out unchanged.
